// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, issues one memory request at a time and
// holds each fetched word for decode. Optional FETCH_ALIGN_CHECK_EN traps misaligned next PCs.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] nPC,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] fetch_cnt,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        capture_s;
    logic        accept_s;
    logic        misalign_s;
    logic [31:0] pc_nxt_s;

    logic [31:0] pc_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_instr_r;
    logic        if_valid_r;
    logic [31:0] fetch_cnt_r;
    logic        fetch_err_r;

    // Masking keeps every nPC bit in use; the low bits only matter to the trap below.
    assign pc_nxt_s = nPC & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_s = (nPC[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_REQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus capture/accept strobes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        accept_s    = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (im_gnt) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (im_rvalid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (if_ready) begin
                    accept_s = 1'b1;
                    if (misalign_s) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_REQ;
            end
        endcase
    end

    // PC, held instruction, handshake flag, counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r        <= RESET_PC;
            if_pc_r     <= RESET_PC;
            if_instr_r  <= 32'h0000_0000;
            if_valid_r  <= 1'b0;
            fetch_cnt_r <= 32'h0000_0000;
            fetch_err_r <= 1'b0;
        end else begin
            if (capture_s) begin
                if_instr_r <= im_rdata;
                if_pc_r    <= pc_r;
                if_valid_r <= 1'b1;
            end
            if (accept_s) begin
                if_valid_r  <= 1'b0;
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
                if (misalign_s) begin
                    fetch_err_r <= 1'b1;
                end else begin
                    pc_r <= pc_nxt_s;
                end
            end
        end
    end

    assign im_req    = (state_r == ST_REQ);
    assign im_addr   = pc_r;
    assign if_valid  = if_valid_r;
    assign if_pc     = if_pc_r;
    assign if_instr  = if_instr_r;
    assign fetch_cnt = fetch_cnt_r;
    assign fetch_err = fetch_err_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; inputs change and outputs are checked on the falling edge.
// Expectations follow FETCH_ALIGN_CHECK_EN when it is defined for the build.
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] nPC;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_cnt;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    pc_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .nPC       (nPC),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_gnt    (im_gnt),
        .im_rvalid (im_rvalid),
        .im_rdata  (im_rdata),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .fetch_cnt (fetch_cnt),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'd0, im_req},   32'd1);
        chk({tag, "_addr"},  im_addr,           32'h0000_3000);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_pc"},    if_pc,             32'h0000_3000);
        chk({tag, "_instr"}, if_instr,          32'h0000_0000);
        chk({tag, "_cnt"},   fetch_cnt,         32'd0);
        chk({tag, "_err"},   {31'd0, fetch_err}, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        nPC       = 32'h0000_0000;
        im_gnt    = 1'b0;
        im_rvalid = 1'b0;
        im_rdata  = 32'h0000_0000;
        if_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");

        // Basic fetch: grant at cycle 0, data at cycle 1, held at cycle 2.
        reset = 1'b1;
        chk("c0_req",  {31'd0, im_req}, 32'd1);
        chk("c0_addr", im_addr, 32'h0000_3000);
        im_gnt = 1'b1;
        @(negedge clk);
        chk("c1_req",   {31'd0, im_req},   32'd0);
        chk("c1_valid", {31'd0, if_valid}, 32'd0);
        im_gnt    = 1'b0;
        im_rvalid = 1'b1;
        im_rdata  = 32'h2402_000A;
        @(negedge clk);
        chk("c2_valid", {31'd0, if_valid}, 32'd1);
        chk("c2_pc",    if_pc,    32'h0000_3000);
        chk("c2_instr", if_instr, 32'h2402_000A);
        im_rvalid = 1'b0;
        if_ready  = 1'b1;
        nPC       = 32'h0000_3004;
        @(negedge clk);
        chk("c3_req",   {31'd0, im_req},   32'd1);
        chk("c3_addr",  im_addr,           32'h0000_3004);
        chk("c3_valid", {31'd0, if_valid}, 32'd0);
        chk("c3_cnt",   fetch_cnt,         32'd1);
        if_ready = 1'b0;

        // Grant withheld 4 cycles, with a spurious rvalid while requesting.
        im_rvalid = 1'b1;
        im_rdata  = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_req",   {31'd0, im_req},   32'd1);
            chk("stall_addr",  im_addr,           32'h0000_3004);
            chk("stall_valid", {31'd0, if_valid}, 32'd0);
        end
        im_rvalid = 1'b0;
        im_gnt    = 1'b1;
        @(negedge clk);
        im_gnt    = 1'b0;
        im_rvalid = 1'b1;
        im_rdata  = 32'h8C22_0004;
        @(negedge clk);
        im_rvalid = 1'b0;

        // Decode stalls 5 cycles while nPC toggles and a spurious grant arrives.
        im_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nPC = (i % 2 == 0) ? 32'h1234_5678 : 32'hDEAD_BEEC;
            @(negedge clk);
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc",    if_pc,             32'h0000_3004);
            chk("hold_instr", if_instr,          32'h8C22_0004);
            chk("hold_req",   {31'd0, im_req},   32'd0);
            chk("hold_cnt",   fetch_cnt,         32'd1);
        end
        im_gnt   = 1'b0;
        nPC      = 32'h0040_0010;
        if_ready = 1'b1;
        @(negedge clk);
        chk("jump_addr", im_addr,         32'h0040_0010);
        chk("jump_req",  {31'd0, im_req}, 32'd1);
        chk("jump_cnt",  fetch_cnt,       32'd2);
        if_ready = 1'b0;

        // Reset while waiting for data; the late response must be dropped.
        im_gnt = 1'b1;
        @(negedge clk);
        chk("wait_req", {31'd0, im_req}, 32'd0);
        im_gnt = 1'b0;
        reset  = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset     = 1'b1;
        im_rvalid = 1'b1;
        im_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("late_valid", {31'd0, if_valid}, 32'd0);
        chk("late_req",   {31'd0, im_req},   32'd1);
        chk("late_addr",  im_addr,           32'h0000_3000);
        chk("late_instr", if_instr,          32'h0000_0000);
        im_rvalid = 1'b0;

        // Misaligned next PC on the handshake.
        im_gnt = 1'b1;
        @(negedge clk);
        im_gnt    = 1'b0;
        im_rvalid = 1'b1;
        im_rdata  = 32'h0000_0020;
        @(negedge clk);
        chk("mis_pc", if_pc, 32'h0000_3000);
        im_rvalid = 1'b0;
        nPC       = 32'h0000_3006;
        if_ready  = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        chk("mis_cnt",   fetch_cnt,         32'd1);
        chk("mis_valid", {31'd0, if_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_err",  {31'd0, fetch_err}, 32'd1);
        chk("mis_req",  {31'd0, im_req},    32'd0);
        chk("mis_addr", im_addr,            32'h0000_3000);
        im_gnt    = 1'b1;
        im_rvalid = 1'b1;
        repeat (2) @(negedge clk);
        chk("err_sticky", {31'd0, fetch_err}, 32'd1);
        chk("err_req",    {31'd0, im_req},    32'd0);
        chk("err_valid",  {31'd0, if_valid},  32'd0);
        im_gnt    = 1'b0;
        im_rvalid = 1'b0;
`else
        chk("mis_err",  {31'd0, fetch_err}, 32'd0);
        chk("mis_req",  {31'd0, im_req},    32'd1);
        chk("mis_addr", im_addr,            32'h0000_3004);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end that owns the architectural PC register and closes the loop with the next-PC calculator. It issues one instruction-memory request at a time over a grant/response handshake. It holds each fetched word in an output register until decode accepts it, then loads the next PC. The next PC is computed combinationally by the next-PC calculator from `if_pc` and the decoded fields of `if_instr`. The block sits between instruction memory and the decode stage of the multi-cycle MIPS datapath.

## Interface
- `RESET_PC`, 32'h0000_3000, first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `nPC`  in  32  next PC from the next-PC calculator; sampled only on the decode handshake.
- `im_req`  out  1  fetch request valid.
- `im_addr`  out  32  word address of the request; equals the PC register.
- `im_gnt`  in  1  memory accepted the request.
- `im_rvalid`  in  1  read data valid.
- `im_rdata`  in  32  instruction word.
- `if_valid`  out  1  `if_instr`/`if_pc` valid to decode.
- `if_ready`  in  1  decode consumes the held instruction.
- `if_pc`  out  32  PC of the held instruction; drives the next-PC calculator's PC input.
- `if_instr`  out  32  held instruction.
- `fetch_cnt`  out  32  number of instructions handed to decode.
- `fetch_err`  out  1  misaligned next PC detected (only with the macro).

## Operation
- State machine: REQ, WAIT, HOLD, ERR.
- REQ
  - `im_req`=1, `im_addr`=PC.
  - On `im_gnt`: go to WAIT. Otherwise stay in REQ and keep the address stable.
- WAIT
  - `im_req`=0.
  - On `im_rvalid`: `if_instr`<=`im_rdata`, `if_pc`<=PC, `if_valid`<=1, go to HOLD.
- HOLD
  - `if_valid`=1.
  - On `if_ready`:
    - PC<=`nPC`
    - `if_valid`<=0
    - `fetch_cnt`<=`fetch_cnt`+1 (wraps 0xFFFFFFFF->0)
    - go to REQ.
- ERR: sticky; `im_req`=0, `if_valid`=0; left only by reset.
- `im_rvalid` outside WAIT is ignored. `im_gnt` outside REQ is ignored.
- Only one request is outstanding; memory never returns `im_rvalid` in the same cycle as `im_gnt`.
- PC arithmetic is not performed here. Address wrap (0xFFFFFFFC->0) is whatever `nPC` supplies.
- Reset values:
  - state=REQ
  - PC=`RESET_PC`
  - `if_pc`=`RESET_PC`
  - `if_instr`=0
  - `if_valid`=0
  - `fetch_cnt`=0
  - `fetch_err`=0
  - `im_req`=1 as soon as reset is deasserted.
- Reset asserted mid-request or mid-hold: all state is cleared immediately and the pending response is discarded. The memory is reset by the same signal.

## Timing
- All outputs are registered except `im_req`/`im_addr`, which decode from the state register and PC.
- Fetch latency with a 1-cycle grant and 1-cycle response:
  - cycle 0: REQ + gnt
  - cycle 1: WAIT + rvalid
  - cycle 2: `if_valid`=1
- Minimum loop per instruction: 3 cycles (REQ, WAIT, HOLD with `if_ready`=1). The next REQ uses the new PC in the cycle after the handshake.
- `nPC` must be stable in the HOLD cycle in which `if_ready`=1.
- `if_instr`/`if_pc` are stable for the entire time `if_valid`=1.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - On the HOLD handshake, if `nPC[1:0]`!=0, PC is not loaded.
  - `fetch_err`<=1, state goes to ERR.
  - `fetch_cnt` still increments for the consumed instruction.
- Not defined:
  - PC<={`nPC[31:2]`,2'b00} (low bits silently cleared).
  - ERR is unreachable.
  - `fetch_err` is tied to 0.

## Test plan
- Reset release, memory grants immediately and returns 0x2402000A one cycle later, `if_ready`=1, `nPC`=0x3004 -> `im_addr`=0x3000 at cycle 0; `if_valid` with `if_pc`=0x3000 and `if_instr`=0x2402000A at cycle 2; `im_addr`=0x3004 at cycle 3; `fetch_cnt`=1.
- `im_gnt` withheld 4 cycles -> `im_req` stays high with `im_addr` constant; no spurious `if_valid`.
- `if_ready` low 5 cycles in HOLD while `nPC` toggles -> `if_instr`/`if_pc` unchanged; PC loads only the `nPC` value present in the accepting cycle (jump to 0x0040_0010).
- Reset asserted while in WAIT, then a late `im_rvalid` -> all outputs at reset values; the late data is ignored; fetch restarts at `RESET_PC`.
- With `FETCH_ALIGN_CHECK_EN`: `nPC`=0x3006 accepted -> `fetch_err`=1, `im_req`=0 thereafter. Without the macro: next `im_addr`=0x3004.
- Spurious `im_rvalid` in REQ and `im_gnt` in HOLD -> no state change.
